// File: rtl/pipe_trace_pkg.sv
// Shared definitions for the DLX pipeline trace buffer: opcodes, capture states and
// the bit layout of one trace record {ts, pc_plus4, opcodes, funcs}.
package pipe_trace_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] FN_NOP   = 6'h15;
  localparam logic [5:0] OP_TRAP  = 6'h11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_t;

  function automatic int rec_w(input int num_stages, input int pc_w, input int ts_w);
    return ts_w + pc_w + 12 * num_stages;
  endfunction

  function automatic int op_lsb(input int num_stages);
    return 6 * num_stages;
  endfunction

  function automatic int pc_lsb(input int num_stages);
    return 12 * num_stages;
  endfunction

  function automatic int ts_lsb(input int num_stages, input int pc_w);
    return 12 * num_stages + pc_w;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// Contents are never reset.
module trace_ram #(
  parameter  int DEPTH = 64,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pipe_trace_buffer.sv
// Circular trace capture for the DLX pipeline; stops POST_TRIG records after TRIG_OP
// reaches write-back. Optional macro TRACE_NOP_FILTER_EN drops write-back NOP cycles.
module pipe_trace_buffer
  import pipe_trace_pkg::*;
#(
  parameter  int         NUM_STAGES = 5,
  parameter  int         DEPTH      = 64,
  parameter  int         PC_W       = 32,
  parameter  int         TS_W       = 16,
  parameter  logic [5:0] TRIG_OP    = OP_TRAP,
  parameter  int         POST_TRIG  = 8,
  localparam int         AW         = $clog2(DEPTH),
  localparam int         REC_W      = rec_w(NUM_STAGES, PC_W, TS_W)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    sample_en,
  input  logic [6*NUM_STAGES-1:0] stage_opcode,
  input  logic [6*NUM_STAGES-1:0] stage_func,
  input  logic [PC_W-1:0]         pc_plus4,
  input  logic                    rd_en,
  input  logic [AW-1:0]           rd_addr,
  output logic                    rd_valid,
  output logic [REC_W-1:0]        rd_data,
  output logic [1:0]              state_o,
  output logic                    done,
  output logic [AW:0]             fill_count,
  output logic [AW-1:0]           trig_index
);

  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_LD = AW'(POST_TRIG);
  localparam int            WB_LSB  = 6 * (NUM_STAGES - 1);

  trace_state_t    state_q, state_d;
  logic [TS_W-1:0] ts_q;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW:0]     fill_q, fill_d;
  logic [AW-1:0]   post_q, post_d;
  logic [AW-1:0]   trig_q, trig_d;
  logic            rd_valid_q;

  logic [5:0]       wb_op;
  logic             wb_nop;
  logic             we;
  logic [AW:0]      trig_full;
  logic [REC_W-1:0] rec;
  logic [AW-1:0]    rd_phys;
  logic             rd_ok;

  assign wb_op = stage_opcode[WB_LSB +: 6];

`ifdef TRACE_NOP_FILTER_EN
  logic [5:0] wb_fn;
  assign wb_fn  = stage_func[WB_LSB +: 6];
  assign wb_nop = (wb_op == OP_RTYPE) && (wb_fn == FN_NOP);
`else
  assign wb_nop = 1'b0;
`endif

  always_comb begin
    rec = '0;
    rec[0 +: 6*NUM_STAGES]                  = stage_func;
    rec[op_lsb(NUM_STAGES) +: 6*NUM_STAGES] = stage_opcode;
    rec[pc_lsb(NUM_STAGES) +: PC_W]         = pc_plus4;
    rec[ts_lsb(NUM_STAGES, PC_W) +: TS_W]   = ts_q;
  end

  // arm has priority over everything, including a trigger in the same cycle
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    fill_d  = fill_q;
    post_d  = post_q;
    trig_d  = trig_q;
    we      = 1'b0;
    if (arm) begin
      state_d = ST_ARMED;
      wptr_d  = '0;
      fill_d  = '0;
    end else if ((state_q == ST_ARMED || state_q == ST_POST) && sample_en && !wb_nop) begin
      we     = 1'b1;
      wptr_d = wptr_q + 1'b1;
      if (fill_q != FULL) fill_d = fill_q + 1'b1;
      if (state_q == ST_ARMED) begin
        if (wb_op == TRIG_OP) begin
          if (POST_TRIG == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_POST;
            post_d  = POST_LD;
          end
        end
      end else begin
        post_d = post_q - 1'b1;
        if (post_q == AW'(1)) state_d = ST_DONE;
      end
    end
    // Trigger's read-order slot: it sits POST_TRIG entries before the newest one
    trig_full = fill_d - (AW+1)'(1) - (AW+1)'(POST_TRIG);
    if (state_d == ST_DONE && state_q != ST_DONE) trig_d = trig_full[AW-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ts_q       <= '0;
      wptr_q     <= '0;
      fill_q     <= '0;
      post_q     <= '0;
      trig_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_q + 1'b1;
      wptr_q     <= wptr_d;
      fill_q     <= fill_d;
      post_q     <= post_d;
      trig_q     <= trig_d;
      rd_valid_q <= rd_ok;
    end
  end

  // Once the buffer has wrapped, the oldest entry sits at the write pointer
  assign rd_phys = (fill_q == FULL) ? (wptr_q + rd_addr) : rd_addr;
  assign rd_ok   = rd_en && (state_q == ST_DONE);

  trace_ram #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wptr_q),
    .wdata_i (rec),
    .re_i    (rd_ok),
    .raddr_i (rd_phys),
    .rdata_o (rd_data)
  );

  assign rd_valid   = rd_valid_q;
  assign state_o    = state_q;
  assign done       = (state_q == ST_DONE);
  assign fill_count = fill_q;
  assign trig_index = trig_q;

endmodule
